imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/rr_arb2.sv | 8 +
 rtl/imem_ctrl.sv | 53 +++++
 tb/tb_imem_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU memory-system types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, FETCH} imc_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; the favoured requester wins when active
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       grant
);
  always_comb grant = req[prio] ? prio : !prio;
endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: round-robin instruction fetch arbiter between two cores and one RAM port
module imem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NCPU    = 2,
  parameter int IADDR_W = 32
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NCPU-1:0]               iREN,
  input  logic [NCPU-1:0][IADDR_W-1:0]  iaddr,
  output logic [NCPU-1:0]               iwait,
  output logic [NCPU-1:0][31:0]         iload,
  input  logic                          dmem_req,
  output logic                          ramREN,
  output logic [IADDR_W-1:0]            ramaddr,
  input  word_t                         ramload,
  input  ramstate_t                     ramstate
);
  imc_state_t state, next_state;
  logic prio, owner, grant, go, hit, done;
  logic [IADDR_W-1:0] addr;
  rr_arb2 u_arb (.req(iREN[1:0]), .prio(prio), .grant(grant));
  // hit drops when the owner withdraws or moves its address, which aborts the fetch
  always_comb begin
    go = state == IDLE && !dmem_req && |iREN;
    hit = iREN[owner] && iaddr[owner] == addr;
    done = state == FETCH && ramstate == ACCESS && hit;
    next_state = state == IDLE ? (go ? FETCH : IDLE) : (hit && !done ? FETCH : IDLE);
    ramREN = state == FETCH;
    ramaddr = addr;
  end
  for (genvar i = 0; i < NCPU; i++) begin : g_core
    always_comb begin
      iwait[i] = !(done && owner == 1'(i));
      iload[i] = (done && owner == 1'(i)) ? ramload : '0;
    end
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      state <= IDLE;
      prio <= 1'b0;
      owner <= 1'b0;
      addr <= '0;
    end else begin
      state <= next_state;
      if (go) begin
        owner <= grant;
        addr <= iaddr[grant];
      end
      if (done) prio <= !owner;
    end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed and random stimulus scored against a transaction-level fetch model
module tb_imem_ctrl;
  import cpu_types_pkg::*;
  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic [1:0]  iwait;
    logic [31:0] ld0, ld1;
  } exp_t;
  logic CLK = 0, nRST = 0, dmem_req = 0, ramREN;
  logic [1:0] iREN = '0, iwait;
  logic [1:0][31:0] iaddr = '0, iload;
  logic [31:0] ramaddr;
  word_t ramload = '0;
  ramstate_t ramstate = FREE;
  int n_chk = 0, n_fail = 0;
  exp_t exp_q[$];
  int served[$];
  word_t served_data[$];
  logic [1:0] got = '0;
  int cur = -1, fav = 0;
  logic [31:0] cur_a = '0;
  imem_ctrl #(.NCPU(2), .IADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dmem_req(dmem_req), .ramREN(ramREN), .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  // Reference: one outstanding fetch (cur = owning core or -1), completes on a matching ACCESS
  always @(negedge CLK) begin
    exp_t e;
    logic fin, keep;
    fin = 0;
    keep = 0;
    if (cur >= 0) begin
      keep = iREN[cur] && iaddr[cur] == cur_a;
      fin = keep && ramstate == ACCESS;
    end
    e.ren = cur >= 0;
    e.addr = cur_a;
    e.iwait = 2'b11;
    e.ld0 = '0;
    e.ld1 = '0;
    if (fin) begin
      e.iwait[cur] = 1'b0;
      if (cur == 0) e.ld0 = ramload; else e.ld1 = ramload;
    end
    exp_q.push_back(e);
    if (!nRST) begin
      cur = -1;
      fav = 0;
      cur_a = '0;
    end else if (cur >= 0) begin
      if (fin) fav = 1 - cur;
      if (fin || !keep) cur = -1;
    end else if (!dmem_req && iREN != 2'b00) begin
      cur = iREN[fav] ? fav : 1 - fav;
      cur_a = iaddr[cur];
    end
  end
  always @(negedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("ramREN", {31'd0, ramREN}, {31'd0, e.ren});
      if (e.ren) check("ramaddr", ramaddr, e.addr);
      check("iwait", {30'd0, iwait}, {30'd0, e.iwait});
      check("iload0", iload[0], e.ld0);
      check("iload1", iload[1], e.ld1);
    end
    got = ~iwait;
    for (int c = 0; c < 2; c++)
      if (iwait[c] === 1'b0) begin
        served.push_back(c);
        served_data.push_back(iload[c]);
      end
  end
  task automatic idle_gap();
    iREN = '0;
    step();
    served.delete();
    served_data.delete();
  endtask
  initial begin
    step(2);
    nRST = 1;
    // single fetch with BUSY wait states
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY;
    step(3);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    step();
    iREN = '0;
    check("busy_fetch_count", served.size(), 1);
    if (served.size() == 1) check("busy_fetch_data", served_data[0], 32'hDEADBEEF);
    idle_gap();
    // both requesting from reset: strict alternation starting with core 0
    nRST = 0; step(); nRST = 1;
    iREN = 2'b11; iaddr[0] = 32'h100; iaddr[1] = 32'h200; ramstate = ACCESS; ramload = 32'h0A0B0C0D;
    step(8);
    check("rr_count", served.size(), 4);
    for (int k = 0; k < 4 && k < served.size(); k++) check("rr_order", served[k], k % 2);
    idle_gap();
    // data side blocks new fetches
    dmem_req = 1; iREN = 2'b10; iaddr[1] = 32'h240;
    step(3);
    check("dmem_block_none", served.size(), 0);
    dmem_req = 0;
    step();
    check("dmem_release_ren", {31'd0, ramREN}, 32'd1);
    ramload = 32'h11112222;
    step();
    check("dmem_release_served", served.size(), 1);
    idle_gap();
    // address change mid-fetch aborts; refetch at the new address
    iREN = 2'b01; iaddr[0] = 32'h80; ramstate = BUSY;
    step(2);
    iaddr[0] = 32'h84;
    step(2);
    check("abort_none", served.size(), 0);
    ramstate = ACCESS; ramload = 32'h12345678;
    step();
    check("abort_refetch_count", served.size(), 1);
    if (served.size() == 1) check("abort_refetch_data", served_data[0], 32'h12345678);
    idle_gap();
    // reset in mid-fetch restores core 0 priority
    iREN = 2'b10; iaddr[1] = 32'h500; ramstate = BUSY;
    step(2);
    nRST = 0;
    step();
    check("rst_ramren", {31'd0, ramREN}, 32'd0);
    check("rst_iwait", {30'd0, iwait}, 32'd3);
    nRST = 1; iREN = 2'b11; iaddr[0] = 32'h600; ramstate = ACCESS;
    step(2);
    check("rst_first_count", served.size(), 1);
    if (served.size() >= 1) check("rst_first_core", served[0], 0);
    idle_gap();
    // ERROR retries, then one completion
    iREN = 2'b10; iaddr[1] = 32'h300; ramstate = ERROR;
    step(4);
    check("error_none", served.size(), 0);
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    step();
    check("error_count", served.size(), 1);
    if (served.size() == 1) check("error_data", served_data[0], 32'hCAFEF00D);
    idle_gap();
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (got[c]) begin
          iREN[c] = 1'($urandom_range(0, 1));
          iaddr[c] = 32'($urandom_range(0, 15)) << 2;
        end else if (!iREN[c]) begin
          if ($urandom_range(0, 2) == 0) begin
            iREN[c] = 1'b1;
            iaddr[c] = 32'($urandom_range(0, 15)) << 2;
          end
        end else if ($urandom_range(0, 19) == 0) begin
          iaddr[c] = 32'($urandom_range(0, 15)) << 2;
        end else if ($urandom_range(0, 29) == 0) begin
          iREN[c] = 1'b0;
        end
      end
      ramstate = ramstate_t'($urandom_range(0, 3));
      dmem_req = $urandom_range(0, 3) == 0;
      ramload = $urandom;
      nRST = $urandom_range(0, 99) != 0;
      step();
    end
    nRST = 1; iREN = '0; dmem_req = 0;
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
